// File: rtl/dnn_ctrl.sv
// dnn_ctrl: sequencer for a 4-4-2 DNN datapath (weight config, input/result handshakes, WAIT timeout).
// Optional feature: define DNN_CTRL_PERF_EN to add the perf_count result-handshake counter port.
module dnn_ctrl #(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_we,
    input  logic [4:0]   cfg_addr,
    input  logic [4:0]   cfg_wdata,
    output logic         cfg_ack,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [19:0]  in_data,
    output logic [19:0]  dnn_x,
    output logic [139:0] dnn_w,
    output logic         dnn_in_ready,
    input  logic [16:0]  dnn_out0,
    input  logic [16:0]  dnn_out1,
    input  logic         dnn_out_ready,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [33:0]  res_data,
`ifdef DNN_CTRL_PERF_EN
    output logic [15:0]  perf_count,
`endif
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [3:0] TO_VAL = 4'(TIMEOUT);

    state_t      state_r;
    state_t      state_nx_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nx_s;
    logic        accept_s;
    logic        cfg_ok_s;
    logic        done_s;
    logic        timeout_s;
    logic        res_hs_s;

    logic        in_ready_r;
    logic        dnn_in_ready_r;
    logic        res_valid_r;
    logic        cfg_ack_r;
    logic        err_r;
    logic [19:0] dnn_x_r;
    logic [33:0] res_data_r;
    logic [4:0]  w_r [28];

    // Next-state, wait counter and per-cycle event decode
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        accept_s   = 1'b0;
        cfg_ok_s   = 1'b0;
        done_s     = 1'b0;
        timeout_s  = 1'b0;
        res_hs_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                accept_s = in_valid;
                cfg_ok_s = cfg_we && (cfg_addr <= 5'd27);
                if (in_valid) begin
                    state_nx_s = S_ISSUE;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_nx_s   = 4'd0;
                state_nx_s = S_WAIT;
            end
            S_WAIT: begin
                if (dnn_out_ready) begin
                    done_s     = 1'b1;
                    state_nx_s = S_OUT;
                end else begin
                    cnt_nx_s = cnt_r + 4'd1;
                    if (cnt_nx_s >= TO_VAL) begin
                        timeout_s  = 1'b1;
                        state_nx_s = S_OUT;
                    end else begin
                        state_nx_s = S_WAIT;
                    end
                end
            end
            S_OUT: begin
                res_hs_s = res_ready;
                if (res_ready) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_OUT;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
                cnt_nx_s   = 4'd0;
            end
        endcase
    end

    // State register; handshake strobes are decoded from the next state so they are registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= S_IDLE;
            cnt_r          <= 4'd0;
            in_ready_r     <= 1'b1;
            dnn_in_ready_r <= 1'b0;
            res_valid_r    <= 1'b0;
            cfg_ack_r      <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            cnt_r          <= cnt_nx_s;
            in_ready_r     <= (state_nx_s == S_IDLE);
            dnn_in_ready_r <= (state_nx_s == S_ISSUE);
            res_valid_r    <= (state_nx_s == S_OUT);
            cfg_ack_r      <= cfg_ok_s;
        end
    end

    // Input vector, result capture and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            dnn_x_r    <= 20'd0;
            res_data_r <= 34'd0;
            err_r      <= 1'b0;
        end else begin
            if (accept_s) begin
                dnn_x_r <= in_data;
            end
            if (done_s) begin
                res_data_r <= {dnn_out1, dnn_out0};
            end else if (timeout_s) begin
                res_data_r <= 34'd0;
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Weight file; only writable while idle, so it is frozen for the whole inference
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 28; k++) begin
                w_r[k] <= 5'd0;
            end
        end else begin
            for (int k = 0; k < 28; k++) begin
                if (cfg_ok_s && (cfg_addr == 5'(k))) begin
                    w_r[k] <= cfg_wdata;
                end
            end
        end
    end

    for (genvar g = 0; g < 28; g++) begin : g_wpack
        assign dnn_w[5*g +: 5] = w_r[g];
    end

`ifdef DNN_CTRL_PERF_EN
    logic [15:0] perf_r;

    // Saturating count of completed result handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_r <= 16'd0;
        end else if (res_hs_s && (perf_r != 16'hFFFF)) begin
            perf_r <= perf_r + 16'd1;
        end
    end

    assign perf_count = perf_r;
`endif

    assign in_ready     = in_ready_r;
    assign dnn_in_ready = dnn_in_ready_r;
    assign res_valid    = res_valid_r;
    assign cfg_ack      = cfg_ack_r;
    assign err          = err_r;
    assign dnn_x        = dnn_x_r;
    assign res_data     = res_data_r;

endmodule
